// File: rtl/sram_controller_if.sv
// MEM-stage request/response bundle for sram_controller.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// 32-bit MEM-stage port onto a 16-bit asynchronous SRAM, one half-word per phase (low, then high).
// Optional macro SRAM_WAIT_EN holds each phase for WAIT_CYCLES extra cycles.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_controller_if.slave    bus,
    inout  logic [15:0]         SRAM_DQ,
    output logic [17:0]         SRAM_ADDR,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N,
    output logic                SRAM_WE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOW  = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;

    logic [2:0]  r_state;
    logic        r_is_write;
    logic [16:0] r_index;
    logic [31:0] r_wdata;
    logic [31:0] r_read_data;

    logic        w_req;
    logic [31:0] w_offset;
    logic        w_active;
    logic        w_half;
    logic        w_sample_lo;
    logic        w_sample_hi;
    logic [15:0] w_dq_out;
    logic        w_unused;

    assign w_req    = bus.wr_en | bus.rd_en;
    assign w_offset = bus.address - BASE_ADDR;
    assign w_unused = &{1'b0, w_offset[31:19], w_offset[1:0], WAIT_CYCLES[0]};

`ifdef SRAM_WAIT_EN
    localparam logic [2:0]          S_WAIT   = 3'd4;
    localparam bit                  HAS_WAIT = (WAIT_CYCLES != 0);
    localparam int unsigned         CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    logic             r_half;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_wait_last;

    // WAIT remembers which half it is holding so address/data/strobes stay frozen.
    assign w_wait_last = (r_state == S_WAIT) && (r_wait_cnt == LAST_CNT);
    assign w_active    = (r_state == S_LOW) || (r_state == S_HIGH) || (r_state == S_WAIT);
    assign w_half      = (r_state == S_HIGH) || ((r_state == S_WAIT) && r_half);
    assign w_sample_lo = HAS_WAIT ? (w_wait_last && !r_half) : (r_state == S_LOW);
    assign w_sample_hi = HAS_WAIT ? (w_wait_last && r_half)  : (r_state == S_HIGH);
`else
    assign w_active    = (r_state == S_LOW) || (r_state == S_HIGH);
    assign w_half      = (r_state == S_HIGH);
    assign w_sample_lo = (r_state == S_LOW);
    assign w_sample_hi = (r_state == S_HIGH);
`endif

    assign w_dq_out  = w_half ? r_wdata[31:16] : r_wdata[15:0];
    assign SRAM_DQ   = (w_active && r_is_write) ? w_dq_out : 'z;
    assign SRAM_ADDR = w_active ? {r_index, w_half} : '0;
    assign SRAM_CE_N = ~w_active;
    assign SRAM_UB_N = ~w_active;
    assign SRAM_LB_N = ~w_active;
    assign SRAM_WE_N = ~(w_active & r_is_write);
    assign SRAM_OE_N = ~(w_active & ~r_is_write);

    assign bus.ready     = (r_state == S_DONE) || ((r_state == S_IDLE) && !w_req);
    assign bus.read_data = r_read_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_is_write  <= 1'b0;
            r_index     <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
`ifdef SRAM_WAIT_EN
            r_half      <= 1'b0;
            r_wait_cnt  <= '0;
`endif
        end else begin
            if (!r_is_write && w_sample_lo) r_read_data[15:0]  <= SRAM_DQ;
            if (!r_is_write && w_sample_hi) r_read_data[31:16] <= SRAM_DQ;

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_write <= bus.wr_en;
                        r_index    <= w_offset[18:2];
                        r_wdata    <= bus.write_data;
                        r_state    <= S_LOW;
                    end
                end
`ifdef SRAM_WAIT_EN
                S_LOW: begin
                    if (HAS_WAIT) begin
                        r_state    <= S_WAIT;
                        r_half     <= 1'b0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (HAS_WAIT) begin
                        r_state    <= S_WAIT;
                        r_half     <= 1'b1;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == LAST_CNT) r_state <= r_half ? S_DONE : S_HIGH;
                    else                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
`else
                S_LOW:  r_state <= S_HIGH;
                S_HIGH: r_state <= S_DONE;
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed scenarios plus randomized traffic
// checked against a word-addressed reference memory.
`timescale 1ns/1ps
module tb_sram_controller;
    localparam logic [31:0] BASE = 32'd1024;
`ifdef SRAM_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif
    localparam int          LAT    = 3 + 2 * W;
    localparam logic [15:0] KEEPER = 16'hC3A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

    sram_controller_if u_bus();

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(u_bus),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
    );

    always #5 clk = ~clk;

    // SRAM device model; when the controller is not writing, the bench drives read data or a keeper pattern.
    logic [15:0] sram_mem [0:262143];
    assign SRAM_DQ = (SRAM_WE_N !== 1'b1) ? 16'hzzzz :
                     ((SRAM_CE_N == 1'b0 && SRAM_OE_N == 1'b0) ? sram_mem[SRAM_ADDR] : KEEPER);
    always @(posedge clk) if (SRAM_CE_N == 1'b0 && SRAM_WE_N == 1'b0) sram_mem[SRAM_ADDR] <= SRAM_DQ;

    int dq_err = 0;
    always @(negedge clk) if (SRAM_WE_N === 1'b1 && SRAM_OE_N === 1'b1 && SRAM_DQ !== KEEPER) dq_err++;

    int checks = 0;
    int passed = 0;
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] ref_rd = '0;

    function automatic int unsigned word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off / 4) % 131072;
    endfunction

    function automatic logic [31:0] sram_word(input int unsigned idx);
        return {sram_mem[2 * idx + 1], sram_mem[2 * idx]};
    endfunction

    task automatic drive_idle();
        u_bus.wr_en = 1'b0; u_bus.rd_en = 1'b0;
        u_bus.address = '0; u_bus.write_data = '0;
    endtask

    task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr,
                              input logic [31:0] data, input string tag);
        int n;
        bit got;
        int unsigned idx;
        idx = word_of(addr);
        @(negedge clk);
        u_bus.wr_en = wr; u_bus.rd_en = rd; u_bus.address = addr; u_bus.write_data = data;
        #1;
        checks++;
        if (u_bus.ready !== 1'b0) $display("FAIL %s ready_on_request got=%b want=0", tag, u_bus.ready);
        else passed++;
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                u_bus.wr_en = 1'b0; u_bus.rd_en = 1'b0;
                u_bus.address = $urandom; u_bus.write_data = $urandom;
            end
            if (u_bus.ready === 1'b1) got = 1;
        end
        if (wr) ref_mem[idx] = data;
        else    ref_rd = ref_mem[idx];
        checks++;
        if (n != LAT) $display("FAIL %s latency got=%0d want=%0d", tag, n, LAT);
        else passed++;
        checks++;
        if (u_bus.read_data !== ref_rd) $display("FAIL %s read_data got=%h want=%h", tag, u_bus.read_data, ref_rd);
        else passed++;
        if (wr) begin
            checks++;
            if (sram_word(idx) !== data) $display("FAIL %s sram_word got=%h want=%h", tag, sram_word(idx), data);
            else passed++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        u_bus.wr_en = 1'b1; u_bus.rd_en = 1'b0;
        u_bus.address = BASE + 32'd8; u_bus.write_data = 32'h0BAD_F00D;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (u_bus.read_data !== 32'd0) $display("FAIL reset_read_data got=%h want=0", u_bus.read_data);
        else passed++;
        checks++;
        if ({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N} !== 5'b11111)
            $display("FAIL reset_strobes got=%b want=11111", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N});
        else passed++;
        checks++;
        if (SRAM_ADDR !== 18'd0 || SRAM_DQ !== KEEPER)
            $display("FAIL reset_bus got addr=%h dq=%h want addr=0 dq=%h", SRAM_ADDR, SRAM_DQ, KEEPER);
        else passed++;
        // request already pending when reset releases: first edge must start the access
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (u_bus.ready !== 1'b0) $display("FAIL reset_release_ready got=%b want=0", u_bus.ready);
        else passed++;
        begin
            int n;
            n = 0;
            while (u_bus.ready !== 1'b1 && n < 40) begin
                @(posedge clk); #1; n++;
                if (n == 1) drive_idle();
            end
            checks++;
            if (n != LAT) $display("FAIL reset_release_latency got=%0d want=%0d", n, LAT);
            else passed++;
        end
        ref_mem[2] = 32'h0BAD_F00D;
        @(posedge clk); #1;
        checks++;
        if (sram_word(2) !== 32'h0BAD_F00D) $display("FAIL reset_release_write got=%h want=0badf00d", sram_word(2));
        else passed++;
    endtask

    task automatic test_directed();
        run_access(1'b1, 1'b0, BASE, 32'hDEAD_BEEF, "write_base");
        checks++;
        if (sram_mem[0] !== 16'hBEEF || sram_mem[1] !== 16'hDEAD)
            $display("FAIL write_base_halves got=%h,%h want=beef,dead", sram_mem[0], sram_mem[1]);
        else passed++;
        run_access(1'b0, 1'b1, BASE, 32'h0, "read_base");
        run_access(1'b1, 1'b1, BASE + 32'd4, 32'h0000_A5A5, "write_wins");
    endtask

    task automatic test_phases(input bit wr, input logic [31:0] addr, input logic [31:0] data, input string tag);
        int unsigned idx;
        logic [31:0] word;
        logic [38:0] got, exp;
        bit half;
        idx = word_of(addr);
        word = wr ? data : ref_mem[idx];
        @(negedge clk);
        u_bus.wr_en = wr; u_bus.rd_en = !wr; u_bus.address = addr; u_bus.write_data = data;
        for (int c = 1; c <= 2 + 2 * W; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive_idle();
            half = (c >= 2 + W);
            exp = {idx[16:0], half, half ? word[31:16] : word[15:0], 4'b0000, wr};
            exp[1] = !wr;
            got = {SRAM_ADDR, SRAM_DQ, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N};
            checks++;
            if (got !== exp) $display("FAIL %s cycle%0d bus got=%h want=%h", tag, c, got, exp);
            else passed++;
        end
        @(posedge clk); #1;
        if (wr) ref_mem[idx] = data;
        else    ref_rd = word;
        checks++;
        if (u_bus.ready !== 1'b1 || u_bus.read_data !== ref_rd)
            $display("FAIL %s done got ready=%b rd=%h want ready=1 rd=%h", tag, u_bus.ready, u_bus.read_data, ref_rd);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        sram_mem[9] = 16'h7777;
        @(negedge clk);
        u_bus.wr_en = 1'b1; u_bus.address = BASE + 32'd16; u_bus.write_data = 32'hCAFE_F00D;
        for (int c = 1; c <= 2 + W; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive_idle();
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (SRAM_WE_N !== 1'b1 || SRAM_CE_N !== 1'b1 || SRAM_DQ !== KEEPER || SRAM_ADDR !== 18'd0)
            $display("FAIL midreset_bus got we=%b ce=%b dq=%h addr=%h want 1 1 %h 0", SRAM_WE_N, SRAM_CE_N, SRAM_DQ, SRAM_ADDR, KEEPER);
        else passed++;
        checks++;
        if (u_bus.read_data !== 32'd0) $display("FAIL midreset_read_data got=%h want=0", u_bus.read_data);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        ref_rd = '0;
        ref_mem.delete(4);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sram_mem[9] !== 16'h7777) $display("FAIL midreset_high_half got=%h want=7777", sram_mem[9]);
        else passed++;
        run_access(1'b0, 1'b1, BASE, 32'h0, "read_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, a2, d1, d2;
        bit exp;
        a1 = BASE + 32'd20; a2 = BASE + 32'd24; d1 = $urandom; d2 = $urandom;
        @(negedge clk);
        u_bus.wr_en = 1'b1; u_bus.address = a1; u_bus.write_data = d1;
        for (int c = 1; c <= 2 * LAT + 1; c++) begin
            @(posedge clk); #1;
            exp = (c == LAT) || (c == 2 * LAT + 1);
            checks++;
            if (u_bus.ready !== exp) $display("FAIL b2b_ready cycle%0d got=%b want=%b", c, u_bus.ready, exp);
            else passed++;
            if (c == LAT) begin u_bus.address = a2; u_bus.write_data = d2; end
        end
        drive_idle();
        ref_mem[word_of(a1)] = d1;
        ref_mem[word_of(a2)] = d2;
        @(posedge clk); #1;
        checks++;
        if (sram_word(word_of(a1)) !== d1 || sram_word(word_of(a2)) !== d2)
            $display("FAIL b2b_words got=%h,%h want=%h,%h", sram_word(word_of(a1)), sram_word(word_of(a2)), d1, d2);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] addr;
        bit wr, rd;
        pool[0] = BASE;              pool[1] = BASE + 32'd4;
        pool[2] = BASE + 32'd40;     pool[3] = BASE + 32'd44;
        pool[4] = 32'd0;             pool[5] = BASE - 32'd4;
        pool[6] = BASE + 32'h8_0004; pool[7] = BASE + 32'h7_FFFC;
        for (int i = 0; i < 40; i++) begin
            addr = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            rd = ($urandom_range(0, 1) == 1) && ref_mem.exists(word_of(addr));
            wr = !rd || ($urandom_range(0, 4) == 0);
            run_access(wr, rd, addr, $urandom, "random");
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_directed();
        test_phases(1'b1, BASE + 32'd12, 32'h1234_5678, "phase_write");
        test_phases(1'b0, BASE + 32'd12, 32'h0, "phase_read");
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        checks++;
        if (dq_err !== 0) $display("FAIL dq_driven_while_we_high got=%0d want=0", dq_err);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter BASE_ADDR, default 1024, the byte address mapped to SRAM word 0.
REQ-002 Parameter WAIT_CYCLES, default 2, the extra cycles per half-access; used only with SRAM_WAIT_EN.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 wr_en  input  1  32-bit write request from the MEM stage.
REQ-006 rd_en  input  1  32-bit read request from the MEM stage.
REQ-007 address  input  32  byte address of the request.
REQ-008 write_data  input  32  write data.
REQ-009 read_data  output  32  registered read result.
REQ-010 ready  output  1  high means the request is complete or no request is pending; low means stall the pipeline.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM half-word address.
REQ-013 SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  output  1 each  active-low SRAM strobes.

Function
REQ-014 The FSM SHALL have the states IDLE, LOW, HIGH and DONE, plus WAIT when SRAM_WAIT_EN is defined.
REQ-015 In IDLE, a request SHALL capture address, write_data and the operation (write wins if wr_en and rd_en are both high); the FSM then goes to LOW.
REQ-016 Request inputs SHALL be ignored outside IDLE; only the captured copies are used.
REQ-017 Word index = ((address - BASE_ADDR) >> 2) truncated to 17 bits, with modulo wrap and no error flag.
REQ-018 The LOW phase SHALL set SRAM_ADDR = {index,0}; the HIGH phase SHALL set SRAM_ADDR = {index,1}.
REQ-019 Write phase: SRAM_WE_N=0; SRAM_DQ driven with write_data[15:0] in LOW and write_data[31:16] in HIGH.
REQ-020 Read phase: SRAM_WE_N=1 and SRAM_OE_N=0; SRAM_DQ is high-Z.
REQ-021 Read phase sampling: SRAM_DQ SHALL be sampled into read_data[15:0] at the end of the last LOW cycle and into read_data[31:16] at the end of the last HIGH cycle.
REQ-022 LOW and HIGH phases: SRAM_CE_N, SRAM_UB_N and SRAM_LB_N SHALL be 0.
REQ-023 IDLE and DONE: CE_N, UB_N, LB_N, WE_N and OE_N SHALL be 1, and SRAM_DQ SHALL be high-Z.
REQ-024 Transitions: HIGH -> DONE, then DONE -> IDLE unconditionally.
REQ-025 Timing: with the request first seen in IDLE at cycle 0, LOW is cycle 1, HIGH is cycle 2, and DONE is cycle 3.
REQ-026 ready = 1 in DONE, and in IDLE with no request; ready = 0 in IDLE with a request, and in LOW/HIGH/WAIT (combinational).
REQ-027 A request still asserted in the cycle after DONE SHALL start a new access; the minimum period is 4 cycles.
REQ-028 read_data SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-029 SRAM_DQ SHALL never be driven while SRAM_WE_N=1.

Reset
REQ-030 While rst_n=0, asynchronously: state=IDLE, read_data=0, all SRAM strobes 1, SRAM_DQ high-Z, SRAM_ADDR=0.
REQ-031 A reset during LOW, HIGH or WAIT SHALL abort the access with no further SRAM writes; a partially written word is permitted.
REQ-032 After release, the first rising edge SHALL evaluate the requests as in IDLE.

Configuration
REQ-033 Macro SRAM_WAIT_EN defined: each LOW and HIGH phase SHALL be followed by WAIT_CYCLES cycles in WAIT with the strobes, address and data held.
REQ-034 With SRAM_WAIT_EN defined, sampling SHALL occur on the last WAIT cycle, and ready SHALL rise at cycle 3+2*WAIT_CYCLES.
REQ-035 Macro SRAM_WAIT_EN undefined: there SHALL be no WAIT state and no wait counter, and the timing of REQ-025 applies.

Verification
REQ-036 wr_en=1, address=1024, write_data=0xDEADBEEF -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; ready low in cycles 0-2 and high in cycle 3.
REQ-037 rd_en=1, address=1024 after REQ-036 -> read_data=0xDEADBEEF in cycle 3; SRAM_DQ is never driven by the controller.
REQ-038 wr_en=1, address=1036, data=0x12345678 -> SRAM_ADDR 6 then 7, receiving 0x5678 then 0x1234.
REQ-039 wr_en=rd_en=1, address=1028, data=0xA5A5 -> a write is performed and read_data is unchanged.
REQ-040 rst_n pulsed low during HIGH of a write -> WE_N=1 and DQ high-Z within the same cycle; read_data=0; state=IDLE.
REQ-041 SRAM_WAIT_EN with WAIT_CYCLES=2, read of 1024 -> ready rises at cycle 7 with correct data; the strobes are stable through WAIT.
